// File: rtl/memory_write_first.sv
// Single-port synchronous RAM, write-first: a write edge also drives the new data onto dout.
// One-cycle registered read; reset clears only the output register, never the array.
module memory_write_first #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    din,
  output logic [DATA_WIDTH-1:0]    dout
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  // Name is fixed: enclosing modules preload it hierarchically.
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [DATA_WIDTH-1:0] dout_reg;

  // Memory write is kept outside the reset branch so a write during reset still commits.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_reg <= '0;
    end else if (we) begin
      dout_reg <= din;
    end else begin
      dout_reg <= mem[addr];
    end
  end

  assign dout = dout_reg;

endmodule

// File: tb/tb_memory_write_first.sv
// Directed check of the write-first RAM with an 8-bit lane instance and a 32-bit instance.
module tb_memory_write_first;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8  = 1'b1;
  logic        we8   = 1'b0;
  logic [3:0]  addr8 = 4'd0;
  logic [7:0]  din8  = 8'd0;
  logic [7:0]  dout8;

  logic        rst32  = 1'b1;
  logic        we32   = 1'b0;
  logic [3:0]  addr32 = 4'd0;
  logic [31:0] din32  = 32'd0;
  logic [31:0] dout32;

  int n_checks = 0;
  int n_fail   = 0;

  memory_write_first #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4)) dut8 (
    .clk  (clk),
    .rst  (rst8),
    .we   (we8),
    .addr (addr8),
    .din  (din8),
    .dout (dout8)
  );

  memory_write_first #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4)) dut32 (
    .clk  (clk),
    .rst  (rst32),
    .we   (we32),
    .addr (addr32),
    .din  (din32),
    .dout (dout32)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  // Apply one access to the 8-bit instance and check dout just after the edge.
  task automatic cyc8(input string tag, input logic r, input logic w, input logic [3:0] a,
                      input logic [7:0] d, input logic [7:0] exp);
    @(negedge clk);
    rst8 = r; we8 = w; addr8 = a; din8 = d;
    @(posedge clk);
    #1;
    check(tag, {24'd0, dout8}, {24'd0, exp});
  endtask

  task automatic cyc32(input string tag, input logic r, input logic w, input logic [3:0] a,
                       input logic [31:0] d, input logic [31:0] exp);
    @(negedge clk);
    rst32 = r; we32 = w; addr32 = a; din32 = d;
    @(posedge clk);
    #1;
    check(tag, dout32, exp);
  endtask

  initial begin
    // Reset held for two cycles with an arbitrary address.
    cyc8("rst_edge1", 1'b1, 1'b0, 4'd5, 8'h00, 8'h00);
    cyc8("rst_edge2", 1'b1, 1'b0, 4'd9, 8'h00, 8'h00);

    // Write-first then read-back.
    cyc8("wf_write3", 1'b0, 1'b1, 4'd3, 8'hA5, 8'hA5);
    cyc8("wf_read3",  1'b0, 1'b0, 4'd3, 8'hFF, 8'hA5);
    #3;
    check("hold_dout", {24'd0, dout8}, 32'h0000_00A5);

    // Independent addresses at both ends of the range.
    cyc8("wr_addr0",   1'b0, 1'b1, 4'd0,  8'h11, 8'h11);
    cyc8("wr_addr15",  1'b0, 1'b1, 4'd15, 8'h22, 8'h22);
    cyc8("rd_addr0",   1'b0, 1'b0, 4'd0,  8'h00, 8'h11);
    cyc8("rd_addr15",  1'b0, 1'b0, 4'd15, 8'h00, 8'h22);
    cyc8("rd_addr0b",  1'b0, 1'b0, 4'd0,  8'h00, 8'h11);

    // Overwrite on consecutive cycles.
    cyc8("ow_first",   1'b0, 1'b1, 4'd7, 8'h5A, 8'h5A);
    cyc8("ow_second",  1'b0, 1'b1, 4'd7, 8'hC3, 8'hC3);
    cyc8("ow_read7",   1'b0, 1'b0, 4'd7, 8'h00, 8'hC3);

    // Preload addr 2, then reset with a pending write to it.
    cyc8("pre_write2", 1'b0, 1'b1, 4'd2, 8'h3C, 8'h3C);
    cyc8("pre_read2",  1'b0, 1'b0, 4'd2, 8'h00, 8'h3C);
    check("pre_mem2", {24'd0, dut8.mem[2]}, 32'h0000_003C);
    cyc8("rst_write2", 1'b1, 1'b1, 4'd2, 8'h77, 8'h00);
    check("rst_mem2", {24'd0, dut8.mem[2]}, 32'h0000_0077);
    cyc8("post_read2", 1'b0, 1'b0, 4'd2, 8'h00, 8'h77);
    cyc8("post_read3", 1'b0, 1'b0, 4'd3, 8'h00, 8'hA5);

    // 32-bit width variant.
    cyc32("w32_rst",    1'b1, 1'b0, 4'd0, 32'h0,         32'h0);
    cyc32("w32_write9", 1'b0, 1'b1, 4'd9, 32'hDEADBEEF,  32'hDEADBEEF);
    cyc32("w32_write4", 1'b0, 1'b1, 4'd4, 32'h12345678,  32'h12345678);
    cyc32("w32_read9",  1'b0, 1'b0, 4'd9, 32'h0,         32'hDEADBEEF);
    cyc32("w32_read4",  1'b0, 1'b0, 4'd4, 32'h0,         32'h12345678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
